riscv_prog_loader: RTL and testbench
====================================

// Module: riscv_prog_loader
// PURPOSE
//  Parametrised program loader and run monitor for the RISC-V cores (single-cycle first).
//  Streams a program from a host valid/ready port into instruction memory through the core's Imem write port.
//  Sequences core reset/start, then watches PC to flag completion (end-PC hit or halt self-loop) or timeout.
//  Synthesisable and usable both in benches and on FPGA.
// PARAMETERS
//  XLEN         32    data/PC width
//  IMEM_DEPTH   256   instruction memory words (power of 2)
//  AW           $clog2(IMEM_DEPTH)  imem word-address width (derived)
//  RST_CYCLES   2     cycles core reset is held after load (>=1)
//  STALL_CYCLES 4     consecutive cycles of unchanged PC that count as a halt (>=2)
//  MAX_CYCLES   4096  run-cycle budget before timeout
//  CW           16    cycle_count width (2**CW > MAX_CYCLES)
// PORTS
//  clk          in   1     clock
//  reset        in   1     asynchronous reset, active-high
//  load_req     in   1     pulse: start load/run sequence
//  load_len     in   AW+1  words to load; 0 = run the existing image
//  host_valid   in   1     host word valid
//  host_data    in   XLEN  host instruction word
//  host_ready   out  1     loader accepts a word this cycle
//  imem_we      out  1     Imem write enable (maps to Imem_write_en)
//  imem_addr    out  AW    Imem word address
//  imem_wdata   out  XLEN  Imem write data (maps to Imem_write_instr)
//  cpu_reset    out  1     core reset, active-high
//  cpu_start    out  1     core run enable (maps to start)
//  pc           in   XLEN  core PC (byte address)
//  end_pc       in   XLEN  completion PC; sampled when load_req is accepted
//  busy         out  1     state is LOAD, RELEASE or RUN
//  done         out  1     sticky: program completed
//  timeout      out  1     sticky: MAX_CYCLES exhausted
//  cycle_count  out  CW    cycles spent in RUN
// BEHAVIOUR
//  Reset (async): state IDLE; host_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1,
//   cpu_start=0, busy=0, done=0, timeout=0, cycle_count=0. All outputs registered.
//  FSM: IDLE -> LOAD -> RELEASE -> RUN -> DONE | FAIL.
//  IDLE/DONE/FAIL: load_req=1 -> clear done/timeout/cycle_count, cpu_reset=1, cpu_start=0,
//   latch end_pc, latch len=min(load_len, IMEM_DEPTH); len>0 -> LOAD, len=0 -> RELEASE.
//   load_req is ignored in LOAD, RELEASE and RUN.
//  LOAD: host_ready=1. Each cycle with host_valid&host_ready: next cycle imem_we=1,
//   imem_addr=idx, imem_wdata=host_data; idx starts at 0, increments by 1.
//   The cycle the len-th word is accepted, host_ready drops and FSM -> RELEASE (last write still issues).
//   host_valid low stalls with no write; no timeout during LOAD.
//  RELEASE: cpu_reset held 1 for RST_CYCLES cycles, then cpu_reset=0 and cpu_start=1 -> RUN.
//  RUN: cycle_count += 1 every cycle (saturates at all-ones).
//   pc==end_pc_latched -> DONE. pc equal to previous-cycle pc for STALL_CYCLES consecutive
//   cycles -> DONE. cycle_count reaches MAX_CYCLES -> FAIL. Completion and timeout in the same cycle: DONE wins.
//  DONE: done=1, cpu_start=0, cpu_reset=0 (core state preserved for inspection).
//  FAIL: timeout=1, cpu_start=0, cpu_reset=0.
//  busy=1 exactly in LOAD, RELEASE and RUN.
//  Reset mid-operation: everything returns to reset values immediately. A partial image stays in
//   Imem; no further writes are issued.
// TESTING
//  1. Reset, then load_req with load_len=3 and words A,B,C streamed back-to-back ->
//     imem_we pulses 3 cycles at addr 0,1,2; cpu_reset falls 2 cycles after the last write; cpu_start=1.
//  2. host_valid toggling 1,0,1 during LOAD -> no write on the gap cycle; addresses stay contiguous;
//     host_ready=0 after the last word.
//  3. end_pc=0x84, bench PC model steps +4 from 0 -> done=1 the cycle after pc=0x84; cycle_count=33; busy=0.
//  4. PC frozen at 0x44 (jal x0,0) -> done=1 after 4 equal cycles; timeout=0.
//  5. MAX_CYCLES=20, PC never hits end_pc and keeps changing -> timeout=1 at cycle_count=20; done=0.
//  6. load_len=300 (>IMEM_DEPTH) -> exactly 256 writes. load_len=0 -> straight to RELEASE.
//     Reset asserted mid-LOAD -> all outputs at reset values; load_req in DONE restarts the sequence.

Source files
------------

// File: rtl/riscv_prog_loader.sv
// Program loader and run monitor for the RISC-V cores: streams a host image into Imem,
// sequences core reset/start, then watches the PC for completion, halt or timeout.
module riscv_prog_loader #(
    parameter int XLEN         = 32,
    parameter int IMEM_DEPTH   = 256,
    parameter int AW           = $clog2(IMEM_DEPTH),
    parameter int RST_CYCLES   = 2,
    parameter int STALL_CYCLES = 4,
    parameter int MAX_CYCLES   = 4096,
    parameter int CW           = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_req,
    input  logic [AW:0]     load_len,
    input  logic            host_valid,
    input  logic [XLEN-1:0] host_data,
    output logic            host_ready,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            cpu_reset,
    output logic            cpu_start,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] end_pc,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [CW-1:0]   cycle_count
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = $clog2(STALL_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t            state, state_nxt;
    logic [AW:0]       load_cnt, load_cnt_nxt;
    logic [AW:0]       len_q, len_nxt;
    logic [XLEN-1:0]   end_pc_q, end_pc_nxt;
    logic [RW-1:0]     rel_cnt, rel_cnt_nxt;
    logic [XLEN-1:0]   prev_pc, prev_pc_nxt;
    logic              prev_valid, prev_valid_nxt;
    logic [SW-1:0]     stall_cnt, stall_nxt;

    logic              host_ready_nxt, imem_we_nxt, cpu_reset_nxt, cpu_start_nxt;
    logic              busy_nxt, done_nxt, timeout_nxt;
    logic [AW-1:0]     imem_addr_nxt;
    logic [XLEN-1:0]   imem_wdata_nxt;
    logic [CW-1:0]     cycle_count_nxt;

    logic [AW:0]       len_clip;
    logic [AW:0]       load_cnt_inc;
    logic [CW-1:0]     cnt_inc;
    logic              pc_same;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            load_cnt    <= '0;
            len_q       <= '0;
            end_pc_q    <= '0;
            rel_cnt     <= '0;
            prev_pc     <= '0;
            prev_valid  <= 1'b0;
            stall_cnt   <= '0;
            host_ready  <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_reset   <= 1'b1;
            cpu_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            load_cnt    <= load_cnt_nxt;
            len_q       <= len_nxt;
            end_pc_q    <= end_pc_nxt;
            rel_cnt     <= rel_cnt_nxt;
            prev_pc     <= prev_pc_nxt;
            prev_valid  <= prev_valid_nxt;
            stall_cnt   <= stall_nxt;
            host_ready  <= host_ready_nxt;
            imem_we     <= imem_we_nxt;
            imem_addr   <= imem_addr_nxt;
            imem_wdata  <= imem_wdata_nxt;
            cpu_reset   <= cpu_reset_nxt;
            cpu_start   <= cpu_start_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            cycle_count <= cycle_count_nxt;
        end
    end

    assign len_clip     = (load_len > (AW+1)'(IMEM_DEPTH)) ? (AW+1)'(IMEM_DEPTH) : load_len;
    assign load_cnt_inc = load_cnt + 1'b1;
    assign cnt_inc      = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
    // The first RUN cycle has no previous PC, so it can never count towards a halt.
    assign pc_same      = prev_valid && (pc == prev_pc);

    always_comb begin
        state_nxt       = state;
        load_cnt_nxt    = load_cnt;
        len_nxt         = len_q;
        end_pc_nxt      = end_pc_q;
        rel_cnt_nxt     = rel_cnt;
        prev_pc_nxt     = prev_pc;
        prev_valid_nxt  = prev_valid;
        stall_nxt       = stall_cnt;
        host_ready_nxt  = 1'b0;
        imem_we_nxt     = 1'b0;
        imem_addr_nxt   = imem_addr;
        imem_wdata_nxt  = imem_wdata;
        cpu_reset_nxt   = cpu_reset;
        cpu_start_nxt   = cpu_start;
        done_nxt        = done;
        timeout_nxt     = timeout;
        cycle_count_nxt = cycle_count;

        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (load_req) begin
                    done_nxt        = 1'b0;
                    timeout_nxt     = 1'b0;
                    cycle_count_nxt = '0;
                    cpu_reset_nxt   = 1'b1;
                    cpu_start_nxt   = 1'b0;
                    end_pc_nxt      = end_pc;
                    len_nxt         = len_clip;
                    load_cnt_nxt    = '0;
                    rel_cnt_nxt     = '0;
                    if (len_clip == '0) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        state_nxt      = ST_LOAD;
                        host_ready_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                host_ready_nxt = 1'b1;
                if (host_valid && host_ready) begin
                    imem_we_nxt    = 1'b1;
                    imem_addr_nxt  = load_cnt[AW-1:0];
                    imem_wdata_nxt = host_data;
                    load_cnt_nxt   = load_cnt_inc;
                    if (load_cnt_inc == len_q) begin
                        state_nxt      = ST_RELEASE;
                        host_ready_nxt = 1'b0;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_cnt == RW'(RST_CYCLES - 1)) begin
                    state_nxt      = ST_RUN;
                    cpu_reset_nxt  = 1'b0;
                    cpu_start_nxt  = 1'b1;
                    prev_valid_nxt = 1'b0;
                    stall_nxt      = '0;
                end else begin
                    rel_cnt_nxt = rel_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                prev_pc_nxt    = pc;
                prev_valid_nxt = 1'b1;
                stall_nxt      = pc_same ? stall_cnt + 1'b1 : '0;
                // Completion is tested first so it beats a timeout landing on the same cycle.
                if ((pc == end_pc_q) || (pc_same && (stall_cnt == SW'(STALL_CYCLES - 1)))) begin
                    state_nxt     = ST_DONE;
                    done_nxt      = 1'b1;
                    cpu_start_nxt = 1'b0;
                end else begin
                    cycle_count_nxt = cnt_inc;
                    if (cnt_inc >= CW'(MAX_CYCLES)) begin
                        state_nxt     = ST_FAIL;
                        timeout_nxt   = 1'b1;
                        cpu_start_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_RELEASE) || (state_nxt == ST_RUN);
    end

endmodule

// File: tb/tb_riscv_prog_loader.sv
// Scoreboard bench for riscv_prog_loader: expected Imem writes and run outcomes are queued at
// stimulus time and popped by monitors when the DUT writes or finishes.
module tb_riscv_prog_loader;

    localparam int XLEN  = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int RSTC  = 2;
    localparam int STALL = 4;
    localparam int MAXC  = 40;
    localparam int CW    = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load_req = 1'b0;
    logic [AW:0]     load_len = '0;
    logic            host_valid = 1'b0;
    logic [XLEN-1:0] host_data = '0;
    logic            host_ready;
    logic            imem_we;
    logic [AW-1:0]   imem_addr;
    logic [XLEN-1:0] imem_wdata;
    logic            cpu_reset;
    logic            cpu_start;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] end_pc = '0;
    logic            busy;
    logic            done;
    logic            timeout;
    logic [CW-1:0]   cycle_count;

    riscv_prog_loader #(
        .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .RST_CYCLES(RSTC),
        .STALL_CYCLES(STALL), .MAX_CYCLES(MAXC), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_start(cpu_start), .pc(pc), .end_pc(end_pc),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          done;
        logic          to;
        logic [CW-1:0] count;
    } res_t;

    wr_t             exp_wr_q[$];
    res_t            exp_run_q[$];
    logic [XLEN-1:0] trace [0:63];
    logic [XLEN-1:0] image [0:511];
    int              run_idx = 0;
    int              checks = 0;
    int              fails = 0;

    // Core PC stand-in: trace[i] is the PC seen in the i-th cycle the core is enabled.
    always @(posedge clk) begin
        if (!cpu_start) run_idx <= 0;
        else if (run_idx < 63) run_idx <= run_idx + 1;
    end
    assign pc = trace[run_idx];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_host_ready"}, host_ready, 0);
        checkOutput({tag, "_imem_we"}, imem_we, 0);
        checkOutput({tag, "_imem_addr"}, imem_addr, 0);
        checkOutput({tag, "_imem_wdata"}, imem_wdata, 0);
        checkOutput({tag, "_cpu_reset"}, cpu_reset, 1);
        checkOutput({tag, "_cpu_start"}, cpu_start, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
        checkOutput({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // Reference outcome: scan the PC trace for end-PC, a run of STALL repeats, or the budget.
    function automatic res_t modelRun(input logic [XLEN-1:0] ep);
        res_t r;
        int   run = 0;
        for (int i = 0; i < MAXC; i++) begin
            if (trace[i] == ep) begin
                r.done = 1'b1; r.to = 1'b0; r.count = CW'(i);
                return r;
            end
            run = (i > 0 && trace[i] == trace[i-1]) ? run + 1 : 0;
            if (run == STALL) begin
                r.done = 1'b1; r.to = 1'b0; r.count = CW'(i);
                return r;
            end
        end
        r.done = 1'b0; r.to = 1'b1; r.count = CW'(MAXC);
        return r;
    endfunction

    function automatic void setTrace(input int mode, input logic [XLEN-1:0] arg);
        logic [XLEN-1:0] p = '0;
        int              freeze_at = $urandom_range(0, 50);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: trace[i] = XLEN'(4 * i);
                1: trace[i] = (XLEN'(4 * i) < arg) ? XLEN'(4 * i) : arg;
                2: trace[i] = XLEN'(32'h100 + 8 * i);
                default: begin
                    trace[i] = p;
                    if (mode == 4 && i >= freeze_at) p = p;
                    else begin
                        case ($urandom_range(0, 9))
                            0, 1, 2, 3, 4: p = p + 4;
                            5, 6:          p = XLEN'($urandom_range(0, 63)) << 2;
                            default:       p = p;
                        endcase
                    end
                end
            endcase
        end
    endfunction

    // One load/run sequence; reset_after >= 0 asserts reset once that many words are accepted.
    task automatic applyStimulus(input int len, input logic [XLEN-1:0] ep, input int vmode,
                                 input int reset_after, input bit poke);
        int  n_exp = (len > DEPTH) ? DEPTH : len;
        int  accepted = 0;
        int  k = 0;
        bit  v, fire;
        wr_t w;
        for (int i = 0; i < n_exp; i++) begin
            image[i] = $urandom;
            w.addr = AW'(i);
            w.data = image[i];
            exp_wr_q.push_back(w);
        end
        if (reset_after < 0) exp_run_q.push_back(modelRun(ep));

        @(negedge clk);
        load_req = 1'b1; load_len = (AW+1)'(len); end_pc = ep;
        @(negedge clk);
        load_req = 1'b0; load_len = (AW+1)'($urandom); end_pc = $urandom;
        checkOutput("start_done_cleared", done, 0);
        checkOutput("start_timeout_cleared", timeout, 0);
        checkOutput("start_cycle_count", cycle_count, 0);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_cpu_reset", cpu_reset, 1);
        checkOutput("start_host_ready", host_ready, (n_exp != 0));

        while (accepted < n_exp) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            host_valid = v;
            host_data  = v ? image[accepted] : $urandom;
            fire       = v && host_ready;
            @(posedge clk);
            if (fire) accepted++;
            k++;
            if (reset_after >= 0 && accepted == reset_after) begin
                #2 reset = 1'b1;
                exp_wr_q.delete();
                #1 checkResetValues("midload");
                @(negedge clk);
                host_valid = 1'b0;
                reset = 1'b0;
                repeat (10) @(negedge clk);
                checkResetValues("after_midload");
                return;
            end
            @(negedge clk);
            if (k > 4 * n_exp + 20) begin
                checkOutput("load_words_accepted", accepted, n_exp);
                break;
            end
        end
        host_valid = 1'b0;
        if (n_exp > 0) checkOutput("host_ready_after_last", host_ready, 0);

        if (poke) begin
            for (int c = 0; c < 20 && !cpu_start; c++) @(negedge clk);
            repeat (3) @(negedge clk);
            load_req = 1'b1; load_len = 9'd5;
            @(negedge clk);
            load_req = 1'b0;
        end

        for (int c = 0; c < 300 && !(done || timeout); c++) @(negedge clk);
        checkOutput("run_completed", done || timeout, 1);
        repeat (3) @(negedge clk);
        checkOutput("writes_outstanding", exp_wr_q.size(), 0);
        checkOutput("runs_outstanding", exp_run_q.size(), 0);
    endtask

    // Write monitor: every Imem write must match the next expected image word.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we) begin
                if (exp_wr_q.size() == 0) checkOutput("write_expected", exp_wr_q.size(), 1);
                else begin
                    e = exp_wr_q.pop_front();
                    checkOutput("imem_addr", imem_addr, e.addr);
                    checkOutput("imem_wdata", imem_wdata, e.data);
                end
            end
        end
    end

    // Run monitor: compare the outcome when done or timeout rises.
    initial begin
        res_t e;
        logic pd = 1'b0, pt = 1'b0;
        forever begin
            @(negedge clk);
            if ((done && !pd) || (timeout && !pt)) begin
                if (exp_run_q.size() == 0) checkOutput("completion_expected", exp_run_q.size(), 1);
                else begin
                    e = exp_run_q.pop_front();
                    checkOutput("done", done, e.done);
                    checkOutput("timeout", timeout, e.to);
                    checkOutput("cycle_count", cycle_count, e.count);
                    checkOutput("busy_at_end", busy, 0);
                    checkOutput("cpu_start_at_end", cpu_start, 0);
                    checkOutput("cpu_reset_at_end", cpu_reset, 0);
                end
            end
            pd = done;
            pt = timeout;
        end
    end

    // Release monitor: core reset must fall RST_CYCLES cycles after the last write.
    initial begin
        int   cyc = 0, last_we = 0;
        bit   wr_since = 1'b0;
        logic pcr = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (imem_we) begin last_we = cyc; wr_since = 1'b1; end
            if (pcr && !cpu_reset) begin
                if (wr_since) checkOutput("release_gap", cyc - last_we, RSTC);
                checkOutput("cpu_start_at_release", cpu_start, 1);
                checkOutput("busy_in_run", busy, 1);
                wr_since = 1'b0;
            end
            if (reset) wr_since = 1'b0;
            pcr = cpu_reset;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setTrace(0, '0);
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("idle");

        setTrace(0, '0);
        applyStimulus(3, 32'h84, 0, -1, 1'b0);
        setTrace(1, 32'h44);
        applyStimulus(3, 32'h1000, 1, -1, 1'b0);
        setTrace(2, '0);
        applyStimulus(4, 32'h8, 2, -1, 1'b1);
        setTrace(0, '0);
        applyStimulus(0, XLEN'(4 * (MAXC - 1)), 0, -1, 1'b0);
        setTrace(0, '0);
        applyStimulus(300, 32'h10, 0, -1, 1'b0);
        applyStimulus(10, 32'h10, 2, 4, 1'b0);

        for (int n = 0; n < 10; n++) begin
            int m = $urandom_range(3, 4);
            setTrace(m, '0);
            applyStimulus($urandom_range(0, 20),
                          ($urandom_range(0, 1) != 0) ? trace[$urandom_range(0, 45)] : 32'hFFFF_FFF0,
                          2, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
